// File: rtl/txn_tagger_pkg.sv
// Shared types for the transaction tagger: request-type encoding, tagged request
// layout and the tagger run/drain state machine encoding.
package txn_tagger_pkg;

  localparam int READ_ENTRIES_LOG = 5;
  localparam int PKG_IDX_W        = READ_ENTRIES_LOG + 1;
  localparam int PKG_ADDR_W       = 27;
  localparam int PKG_DATA_W       = 32;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } tagger_state_e;

  typedef struct packed {
    req_type_e               the_type;
    logic [PKG_ADDR_W-1:0]   addr;
    logic [PKG_DATA_W-1:0]   data;
    logic [PKG_IDX_W-1:0]    index;
  } tagged_req_t;

endpackage

// File: rtl/txn_tagger_credit_ctr.sv
// Saturating up/down outstanding-request counter; a simultaneous inc and dec
// cancel, and a dec at zero is dropped.
module txn_credit_ctr #(
  parameter int CNT_W = 7,
  parameter int MAX   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    full    = (count_q >= MAX_C);
    empty   = (count_q == '0);
    count_d = count_q;
    if (inc && !dec && !full) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && !empty) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/txn_tagger.sv
// Tags read/write requests with per-type sequence indices, limits outstanding
// requests per type and offers a drain handshake. Optional: TXN_TAGGER_ERR_EN.
module txn_tagger
  import txn_tagger_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 27,
  parameter int IDX_W   = 6,
  parameter int MAX_OUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_type,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_type,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  input  logic              read_done,
  input  logic              write_done,
  input  logic              drain_req,
  output logic              drain_done,
  output logic [IDX_W:0]    rd_outstanding,
  output logic [IDX_W:0]    wr_outstanding
`ifdef TXN_TAGGER_ERR_EN
  ,
  output logic              err_flag
`endif
);

  typedef struct packed {
    req_type_e          the_type;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [IDX_W-1:0]   index;
  } req_t;

  tagger_state_e    state_q, state_d;
  req_t             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic             rd_full, rd_empty, wr_full, wr_empty;
  logic             is_read, credit_ok, accept, rd_inc, wr_inc;

  // in_ready drops in the same cycle drain_req rises, ahead of the state change
  always_comb begin
    is_read   = (in_type == REQ_READ);
    credit_ok = is_read ? !rd_full : !wr_full;
    in_ready  = (state_q == RUN) && !drain_req && (!out_valid_q || out_ready) && credit_ok;
    accept    = in_valid && in_ready;
    rd_inc    = accept && is_read;
    wr_inc    = accept && !is_read;
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      out_d.the_type = req_type_e'(in_type);
      out_d.addr     = in_addr;
      out_d.data     = in_data;
      out_d.index    = is_read ? rd_idx_q : wr_idx_q;
      if (is_read) begin
        rd_idx_d = rd_idx_q + 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (!out_valid_q && rd_empty && wr_empty) state_d = DRAINED;
      DRAINED: if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
    end
  end

  txn_credit_ctr #(.CNT_W(IDX_W + 1), .MAX(MAX_OUT)) u_rd_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (rd_inc),
    .dec   (read_done),
    .count (rd_outstanding),
    .full  (rd_full),
    .empty (rd_empty)
  );

  txn_credit_ctr #(.CNT_W(IDX_W + 1), .MAX(MAX_OUT)) u_wr_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (wr_inc),
    .dec   (write_done),
    .count (wr_outstanding),
    .full  (wr_full),
    .empty (wr_empty)
  );

  assign out_valid  = out_valid_q;
  assign out_type   = out_q.the_type;
  assign out_addr   = out_q.addr;
  assign out_data   = out_q.data;
  assign out_index  = out_q.index;
  assign drain_done = (state_q == DRAINED);

`ifdef TXN_TAGGER_ERR_EN
  // Sticky: a retire with nothing outstanding, or an issue past the credit limit
  logic err_flag_r, err_flag_d;

  always_comb begin
    err_flag_d = err_flag_r
               | (read_done && rd_empty) | (write_done && wr_empty)
               | (rd_inc && rd_full)     | (wr_inc && wr_full);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flag_r <= 1'b0;
    end else begin
      err_flag_r <= err_flag_d;
    end
  end

  assign err_flag = err_flag_r;
`endif

endmodule

// File: doc/txn_tagger.md
Name: txn_tagger

Overview:
- Upstream stage of the TXN_controller returner: accepts front-end read/write requests, stamps each with a per-type sequential index, and forwards them to the scheduler/memory path.
- Tracks outstanding reads and writes using returner read_done/write_done, so the returner's 64-entry reorder window is never overrun.
- Provides a drain handshake so software or control logic can quiesce the controller.

Parameters:
DATA_W, 32, request data width in bits
ADDR_W, 27, request address width in bits
IDX_W, 6, index width; equals read_entries_log+1 from types_def; window = 2**IDX_W
MAX_OUT, 64, maximum outstanding requests per type; must be <= 2**IDX_W

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  front-end request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_type  in  1  request type, read/write encoding from types_def
in_addr  in  ADDR_W  request address
in_data  in  DATA_W  write data, don't-care for reads
out_valid  out  1  tagged request valid to scheduler
out_ready  in  1  scheduler accepts when out_valid && out_ready
out_type  out  1  registered type
out_addr  out  ADDR_W  registered address
out_data  out  DATA_W  registered data
out_index  out  IDX_W  per-type sequence index
read_done  in  1  pulse from returner: one read retired in order
write_done  in  1  pulse from returner: one write retired in order
drain_req  in  1  level; stop accepting and empty the pipe
drain_done  out  1  high while drained
rd_outstanding  out  IDX_W+1  reads issued but not retired
wr_outstanding  out  IDX_W+1  writes issued but not retired

Behaviour:
- Reset (rst low, async): out_valid=0, out_type/addr/data/index=0, rd_idx=wr_idx=0, rd_outstanding=wr_outstanding=0, drain_done=0, FSM=RUN.
- Output stage is a single register:
  - in_ready = (state==RUN) && (!out_valid || out_ready) && credit_ok.
  - credit_ok = (in_type==read) ? rd_outstanding<MAX_OUT : wr_outstanding<MAX_OUT.
  - in_ready may depend combinationally on in_type; in_type is valid only while in_valid is high.
- On accept: the output register loads the request next cycle (latency 1).
  - out_index = rd_idx for reads, wr_idx for writes.
  - The matching index increments mod 2**IDX_W (63 wraps to 0). The other index is untouched.
- Output hold: out_valid stays high with stable payload until out_ready. Back-to-back accept with out_ready=1 gives 1 request/cycle.
- Outstanding counters:
  - Increment on accept of that type.
  - Decrement on the matching *_done pulse.
  - Accept and done of the same type in the same cycle leave the counter unchanged.
  - read_done and write_done are independent and may coincide.
  - A done pulse while the counter is 0 is ignored; the counter saturates at 0.
- FSM:
  - RUN: accepting. If drain_req=1, go to DRAIN; in_ready drops the same cycle drain_req is sampled high.
  - DRAIN: no accepts. Go to DRAINED when !out_valid && rd_outstanding==0 && wr_outstanding==0.
  - DRAINED: drain_done=1. Return to RUN when drain_req=0; drain_done=0 in RUN.
  - Reset mid-drain returns to RUN with all counters cleared. Indices restart at 0, and the returner resets in the same domain.

Optional Feature:
TXN_TAGGER_ERR_EN:
- When defined, adds output err_flag (1 bit) and sticky register err_flag_r.
- err_flag_r is set on any done pulse while the corresponding counter is 0, or on any accept while the counter is at MAX_OUT (a defensive check).
- err_flag_r clears only on reset.
- When undefined: no port, no register; underflow is silently ignored as above.

Decomposition:
- types_def package: request-type read/write encoding, read_entries_log, a tagged-request packed struct {the_type, addr, data, index}, and a tagger_state enum {RUN, DRAIN, DRAINED}.
- One natural sub-module, txn_credit_ctr: a saturating up/down counter with inc, dec, count, full, empty outputs. It is instantiated twice (reads, writes).

Test Plan:
- Reset then 3 reads, 2 writes with out_ready=1: out_index reads 0,1,2 and writes 0,1; rd_outstanding=3, wr_outstanding=2; each appears 1 cycle after accept.
- 64 reads with no read_done: in_ready=0 on the 65th read while a write is still accepted. One read_done pulse raises in_ready next cycle, and that read gets out_index=0 (wrap).
- out_ready held 0 for 5 cycles with in_valid=1: out_valid stays 1, payload stable, in_ready=0. Release gives exactly one transfer; no loss or duplication.
- Same-cycle read accept plus read_done at rd_outstanding=10: stays 10. read_done at rd_outstanding=0: stays 0 (err_flag=1 with TXN_TAGGER_ERR_EN).
- drain_req with 4 reads outstanding: in_ready=0 immediately; drain_done=1 one cycle after the 4th read_done. Dropping drain_req returns to RUN.
- rst asserted mid-transfer, asynchronously between clock edges: outputs clear immediately; after release, the first read gets out_index=0.
